// File: rtl/toggle_monitor.sv
// Synchronises an asynchronous toggle signal, counts its edges and reports a threshold snapshot.
// Optional macro TOGGLE_MONITOR_GLITCH_FILTER_EN adds a 2-cycle stability filter before edge detect.
module toggle_monitor #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned THRESH      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_in,
  input  logic             clr,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] cnt,
  output logic             thresh_hit,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count
);

  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ThreshVal = CNT_W'(THRESH);

  typedef enum logic [1:0] {StIdle, StReport, StDone} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   qs;
  logic                   rise, fall;
  logic                   rise_q, fall_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   thresh_q, thresh_d;
  logic                   hit;
  logic [CNT_W-1:0]       rpt_count_q;
  state_e                 state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], q_in};
  end

  assign qs = sync_q[SYNC_STAGES-1];

`ifdef TOGGLE_MONITOR_GLITCH_FILTER_EN
  logic qs_prev_q, filt_q, filt_d;

  // Accept a new level only once qs has held it for two consecutive cycles.
  assign filt_d = (qs == qs_prev_q) ? qs : filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qs_prev_q <= 1'b0;
      filt_q    <= 1'b0;
    end else begin
      qs_prev_q <= qs;
      filt_q    <= filt_d;
    end
  end

  assign rise = filt_d & ~filt_q;
  assign fall = ~filt_d & filt_q;
`else
  logic q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_d <= 1'b0;
    else        q_d <= qs;
  end

  assign rise = qs & ~q_d;
  assign fall = ~qs & q_d;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if ((rise_q || fall_q) && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // clr forces cnt_d to zero, so a hit can never coincide with a clear.
  assign hit      = (cnt_d == ThreshVal) && (cnt_q != ThreshVal);
  assign thresh_d = clr ? 1'b0 : (thresh_q | hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      cnt_q       <= '0;
      thresh_q    <= 1'b0;
      rpt_count_q <= '0;
    end else begin
      rise_q   <= rise;
      fall_q   <= fall;
      cnt_q    <= cnt_d;
      thresh_q <= thresh_d;
      if ((state_q == StIdle) && hit) rpt_count_q <= ThreshVal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (hit) state_d = StReport;
      StReport: if (rpt_ready) state_d = StDone;
      StDone:   state_d = StDone;
      default:  state_d = StIdle;
    endcase
    if (clr) state_d = StIdle;
  end

  always_comb begin
    rpt_valid = (state_q == StReport);
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign cnt        = cnt_q;
  assign thresh_hit = thresh_q;
  assign rpt_count  = rpt_count_q;

endmodule
